alu_resp_checker: RTL and testbench

Synthesizable response checker on the result side of the 8-bit two-operand ALU (`op1`, `op2`, 2-bit `sel`, 9-bit `s_out`). It accepts one operand/result transaction per cycle over a valid/ready handshake and recomputes the expected result. It counts passes and failures, and latches the first failing transaction for debug. It sits after the ALU in self-checking builds and FPGA bring-up, and halts intake on the first failure when configured to.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_ref_model.sv | 29 ++
 rtl/alu_resp_checker.sv | 115 +++++++++++
 tb/tb_alu_resp_checker.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, default width and the golden
// result function used by the response checker and any ALU model.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_e;

  localparam int DATA_W = 8;

  // Widest operand the golden function handles; callers zero-extend into it.
  localparam int REF_W = 64;

  // Truncating the wide result to DATA_W+1 bits gives the carry-in-MSB add
  // and the modulo-2^(DATA_W+1) subtract.
  function automatic logic [REF_W:0] alu_ref(
    input alu_op_e          op,
    input logic [REF_W-1:0] a,
    input logic [REF_W-1:0] b
  );
    logic [REF_W:0] ea;
    logic [REF_W:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    case (op)
      ADD:     return ea + eb;
      SUB:     return ea - eb;
      AND:     return ea & eb;
      default: return ea | eb;
    endcase
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational expected-result generator for one ALU transaction, sized to
// the checker's operand width.
module alu_ref_model #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W:0]   exp_res
);
  import alu_pkg::*;

  logic [REF_W-1:0] a;
  logic [REF_W-1:0] b;
  logic [REF_W:0]   full;
  logic             unused_hi;

  always_comb begin
    a              = '0;
    b              = '0;
    a[DATA_W-1:0]  = op1;
    b[DATA_W-1:0]  = op2;
    full           = alu_ref(alu_op_e'(sel), a, b);
  end

  assign exp_res   = full[DATA_W:0];
  assign unused_hi = ^full[REF_W:DATA_W+1];

endmodule

// File: rtl/alu_resp_checker.sv
// Two-stage ALU response checker: recompute, compare, count passes/fails,
// capture the first failure and optionally halt intake until cleared.
module alu_resp_checker #(
  parameter int DATA_W       = alu_pkg::DATA_W,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [1:0]        sel,
  input  logic [DATA_W:0]   s_out,
  input  logic              clear,
  output logic              res_valid,
  output logic              res_pass,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err,
  output logic [DATA_W-1:0] fail_op1,
  output logic [DATA_W-1:0] fail_op2,
  output logic [1:0]        fail_sel,
  output logic [DATA_W:0]   fail_got,
  output logic [DATA_W:0]   fail_exp
);
  import alu_pkg::*;

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state;
  logic [DATA_W:0]   exp_res;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_op1;
  logic [DATA_W-1:0] s1_op2;
  logic [1:0]        s1_sel;
  logic [DATA_W:0]   s1_got;
  logic [DATA_W:0]   s1_exp;
  logic              accept;
  logic              flush;
  logic              mismatch;

  alu_ref_model #(.DATA_W(DATA_W)) u_ref (
    .sel     (sel),
    .op1     (op1),
    .op2     (op2),
    .exp_res (exp_res)
  );

  assign in_ready = (state == RUN);
  assign accept   = in_valid & in_ready;
  assign flush    = ~rst_n | clear;
  assign mismatch = s1_valid & (s1_got != s1_exp);

  always_ff @(posedge clk) begin
    if (flush) begin
      s1_valid <= 1'b0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_sel   <= '0;
      s1_got   <= '0;
      s1_exp   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op1 <= op1;
        s1_op2 <= op2;
        s1_sel <= sel;
        s1_got <= s_out;
        s1_exp <= exp_res;
      end
    end
  end

  // Only the first failure while err is clear is captured; in-flight work
  // after a halt still completes and counts.
  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= RUN;
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err       <= 1'b0;
      fail_op1  <= '0;
      fail_op2  <= '0;
      fail_sel  <= '0;
      fail_got  <= '0;
      fail_exp  <= '0;
    end else begin
      res_valid <= s1_valid;
      res_pass  <= s1_valid & ~mismatch;
      if (s1_valid && !mismatch && pass_cnt != CNT_MAX)
        pass_cnt <= pass_cnt + CNT_W'(1);
      if (mismatch) begin
        if (fail_cnt != CNT_MAX)
          fail_cnt <= fail_cnt + CNT_W'(1);
        if (!err) begin
          err      <= 1'b1;
          fail_op1 <= s1_op1;
          fail_op2 <= s1_op2;
          fail_sel <= s1_sel;
          fail_got <= s1_got;
          fail_exp <= s1_exp;
        end
        if (STOP_ON_FAIL)
          state <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_alu_resp_checker.sv
// Bench for alu_resp_checker: a default instance plus a 2-bit-counter,
// non-halting instance sharing the same stimulus.
module tb_alu_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, clear;
  logic [7:0] op1, op2;
  logic [1:0] sel;
  logic [8:0] s_out;

  logic        in_ready, res_valid, res_pass, err;
  logic [15:0] pass_cnt, fail_cnt;
  logic [7:0]  fail_op1, fail_op2;
  logic [1:0]  fail_sel;
  logic [8:0]  fail_got, fail_exp;

  logic       sat_in_ready, sat_res_valid, sat_res_pass, sat_err;
  logic [1:0] sat_pass_cnt, sat_fail_cnt;
  logic [7:0] sat_fail_op1, sat_fail_op2;
  logic [1:0] sat_fail_sel;
  logic [8:0] sat_fail_got, sat_fail_exp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_resp_checker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .sel(sel), .s_out(s_out), .clear(clear),
    .res_valid(res_valid), .res_pass(res_pass), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .err(err), .fail_op1(fail_op1), .fail_op2(fail_op2),
    .fail_sel(fail_sel), .fail_got(fail_got), .fail_exp(fail_exp)
  );

  alu_resp_checker #(.DATA_W(8), .CNT_W(2), .STOP_ON_FAIL(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .op1(op1), .op2(op2), .sel(sel), .s_out(s_out), .clear(clear),
    .res_valid(sat_res_valid), .res_pass(sat_res_pass), .pass_cnt(sat_pass_cnt),
    .fail_cnt(sat_fail_cnt), .err(sat_err), .fail_op1(sat_fail_op1),
    .fail_op2(sat_fail_op2), .fail_sel(sat_fail_sel), .fail_got(sat_fail_got),
    .fail_exp(sat_fail_exp)
  );

  // Reference result from the operation definitions, in plain integer arithmetic.
  function automatic logic [8:0] model_exp(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s);
    int ia, ib, r;
    ia = a;
    ib = b;
    case (s)
      2'd0:    r = ia + ib;
      2'd1:    r = (ia - ib + 512) % 512;
      2'd2:    r = ia & ib;
      default: r = ia | ib;
    endcase
    return r[8:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] s, input logic [8:0] r);
    in_valid = v;
    op1      = a;
    op2      = b;
    sel      = s;
    s_out    = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 9'h000);
    repeat (2) step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_in_ready got=%0b want=1", in_ready);
    end
    checks++;
    if ({res_valid, res_pass, err, pass_cnt, fail_cnt} !== 35'd0) begin
      failures++; $display("[TB] FAIL reset_status got=%0h want=0",
                           {res_valid, res_pass, err, pass_cnt, fail_cnt});
    end
    checks++;
    if ({fail_op1, fail_op2, fail_sel, fail_got, fail_exp} !== 36'd0) begin
      failures++; $display("[TB] FAIL reset_capture got=%0h want=0",
                           {fail_op1, fail_op2, fail_sel, fail_got, fail_exp});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed_pass();
    logic [7:0] va [5] = '{8'hFF, 8'hFF, 8'hE7, 8'hF3, 8'hCF};
    logic [7:0] vb [5] = '{8'hFF, 8'hFF, 8'hF3, 8'hCF, 8'hFB};
    logic [1:0] vs [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic [8:0] vr [5] = '{9'h1FE, 9'h000, 9'h1F4, 9'h0C3, 9'h0FF};
    logic       want;
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) drive(1'b1, va[k], vb[k], vs[k], vr[k]);
      else       drive(1'b0, 8'h00, 8'h00, 2'b00, 9'h000);
      step();
      if (k > 0) begin
        want = (model_exp(va[k-1], vb[k-1], vs[k-1]) == vr[k-1]);
        checks++;
        if ({res_valid, res_pass} !== {1'b1, want}) begin
          failures++; $display("[TB] FAIL directed_result%0d got=%0b%0b want=1%0b",
                               k - 1, res_valid, res_pass, want);
        end
      end
    end
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL directed_pulse got=%0b want=0", res_valid);
    end
    checks++;
    if ({pass_cnt, err} !== {16'd5, 1'b0}) begin
      failures++; $display("[TB] FAIL directed_counts got=%0d/%0b want=5/0", pass_cnt, err);
    end
  endtask

  task automatic test_stop_on_fail();
    drive(1'b1, 8'hFF, 8'hFF, 2'b00, 9'h0FE);
    step();
    drive(1'b1, 8'h01, 8'h01, 2'b00, 9'h002);
    step();
    checks++;
    if ({res_valid, res_pass, err, in_ready} !== 4'b1010) begin
      failures++; $display("[TB] FAIL halt_verdict got=%0b want=1010",
                           {res_valid, res_pass, err, in_ready});
    end
    checks++;
    if ({fail_op1, fail_op2, fail_sel, fail_got, fail_exp} !==
        {8'hFF, 8'hFF, 2'b00, 9'h0FE, 9'h1FE}) begin
      failures++; $display("[TB] FAIL halt_capture got=%0h want=%0h",
                           {fail_op1, fail_op2, fail_sel, fail_got, fail_exp},
                           {8'hFF, 8'hFF, 2'b00, 9'h0FE, 9'h1FE});
    end
    drive(1'b1, 8'h10, 8'h20, 2'b00, 9'h000);
    step();
    checks++;
    if ({res_valid, res_pass, pass_cnt, fail_cnt, fail_got} !== {2'b11, 16'd6, 16'd1, 9'h0FE}) begin
      failures++; $display("[TB] FAIL halt_inflight got=%0b%0b p=%0d f=%0d g=%0h want=11 p=6 f=1 g=0fe",
                           res_valid, res_pass, pass_cnt, fail_cnt, fail_got);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({res_valid, in_ready} !== 2'b00) begin
        failures++; $display("[TB] FAIL halt_ignore%0d got=%0b%0b want=00", k, res_valid, in_ready);
      end
    end
    checks++;
    if ({pass_cnt, fail_cnt} !== {16'd6, 16'd1}) begin
      failures++; $display("[TB] FAIL halt_counts got=%0d/%0d want=6/1", pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_clear_halt();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 9'h000);
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({in_ready, res_valid, err, pass_cnt, fail_cnt} !== {1'b1, 34'd0}) begin
      failures++; $display("[TB] FAIL clear_status got=%0h want=%0h",
                           {in_ready, res_valid, err, pass_cnt, fail_cnt}, {1'b1, 34'd0});
    end
    checks++;
    if ({fail_op1, fail_op2, fail_sel, fail_got, fail_exp} !== 36'd0) begin
      failures++; $display("[TB] FAIL clear_capture got=%0h want=0",
                           {fail_op1, fail_op2, fail_sel, fail_got, fail_exp});
    end
    drive(1'b1, 8'h00, 8'h00, 2'b00, 9'h000);
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 9'h000);
    step();
    checks++;
    if ({res_valid, res_pass, pass_cnt} !== {2'b11, 16'd1}) begin
      failures++; $display("[TB] FAIL clear_restart got=%0b%0b p=%0d want=11 p=1",
                           res_valid, res_pass, pass_cnt);
    end
  endtask

  task automatic test_clear_collision();
    drive(1'b1, 8'h12, 8'h34, 2'b00, model_exp(8'h12, 8'h34, 2'b00));
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 9'h000);
    step();
    checks++;
    if ({res_valid, pass_cnt} !== 17'd0) begin
      failures++; $display("[TB] FAIL clear_same_cycle got=%0b p=%0d want=0 p=0", res_valid, pass_cnt);
    end
    drive(1'b1, 8'h56, 8'h21, 2'b01, model_exp(8'h56, 8'h21, 2'b01));
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 9'h000);
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    checks++;
    if ({res_valid, pass_cnt} !== 17'd0) begin
      failures++; $display("[TB] FAIL clear_inflight got=%0b p=%0d want=0 p=0", res_valid, pass_cnt);
    end
  endtask

  task automatic test_reset_inflight();
    drive(1'b1, 8'h0F, 8'hF0, 2'b11, model_exp(8'h0F, 8'hF0, 2'b11));
    step();
    drive(1'b1, 8'h80, 8'h80, 2'b00, model_exp(8'h80, 8'h80, 2'b00));
    step();
    checks++;
    if (pass_cnt !== 16'd1) begin
      failures++; $display("[TB] FAIL rst_pre_count got=%0d want=1", pass_cnt);
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 9'h000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({in_ready, res_valid, res_pass, err, pass_cnt, fail_cnt} !== {1'b1, 35'd0}) begin
      failures++; $display("[TB] FAIL rst_inflight got=%0h want=%0h",
                           {in_ready, res_valid, res_pass, err, pass_cnt, fail_cnt}, {1'b1, 35'd0});
    end
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_discard got=%0b want=0", res_valid);
    end
  endtask

  task automatic test_random_pass();
    logic       acc, pend;
    logic [7:0] a, b;
    logic [1:0] s;
    int         exp_cnt;
    pend    = 1'b0;
    exp_cnt = 0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rand_ready got=%0b want=1", in_ready);
    end
    for (int i = 0; i <= 41; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      s   = 2'($urandom);
      acc = (i < 40) && ($urandom_range(0, 3) != 0);
      drive(acc, a, b, s, model_exp(a, b, s));
      step();
      checks++;
      if ({res_valid, res_pass} !== {pend, pend}) begin
        failures++; $display("[TB] FAIL rand_pass_cycle%0d got=%0b%0b want=%0b%0b",
                             i, res_valid, res_pass, pend, pend);
      end
      if (pend) exp_cnt++;
      pend = acc;
    end
    checks++;
    if (pass_cnt !== 16'(exp_cnt)) begin
      failures++; $display("[TB] FAIL rand_pass_count got=%0d want=%0d", pass_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] a, b;
    logic [1:0] s;
    logic [8:0] r;
    logic [35:0] first;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 9'h000);
    clear = 1'b1;
    step();
    clear = 1'b0;
    first = '0;
    for (int k = 0; k <= 9; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 2'($urandom);
      r = model_exp(a, b, s);
      if (k >= 5) r = r ^ 9'($urandom_range(1, 511));
      if (k == 5) first = {a, b, s, r, model_exp(a, b, s)};
      drive(k < 9, a, b, s, r);
      step();
      if (k == 5) begin
        checks++;
        if (sat_pass_cnt !== 2'd3) begin
          failures++; $display("[TB] FAIL sat_pass got=%0d want=3", sat_pass_cnt);
        end
      end
    end
    step();
    checks++;
    if ({sat_fail_cnt, sat_pass_cnt, sat_err, sat_in_ready} !== {2'd3, 2'd3, 2'b11}) begin
      failures++; $display("[TB] FAIL sat_fail got=f%0d p%0d e%0b r%0b want=f3 p3 e1 r1",
                           sat_fail_cnt, sat_pass_cnt, sat_err, sat_in_ready);
    end
    checks++;
    if ({sat_fail_op1, sat_fail_op2, sat_fail_sel, sat_fail_got, sat_fail_exp} !== first) begin
      failures++; $display("[TB] FAIL sat_first_capture got=%0h want=%0h",
                           {sat_fail_op1, sat_fail_op2, sat_fail_sel, sat_fail_got, sat_fail_exp}, first);
    end
  endtask

  task automatic test_random_mixed();
    logic        acc, bad, pend, pend_pass, seen;
    logic [7:0]  a, b;
    logic [1:0]  s;
    logic [8:0]  r;
    logic [35:0] first;
    int          np, nf;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 9'h000);
    clear = 1'b1;
    step();
    clear     = 1'b0;
    pend      = 1'b0;
    pend_pass = 1'b0;
    seen      = 1'b0;
    first     = '0;
    np        = 0;
    nf        = 0;
    for (int i = 0; i <= 31; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      s   = 2'($urandom);
      acc = (i < 30) && ((i == 3) || ($urandom_range(0, 4) != 0));
      bad = (i == 3) || ($urandom_range(0, 2) == 0);
      r   = model_exp(a, b, s);
      if (bad) r = r ^ 9'($urandom_range(1, 511));
      drive(acc, a, b, s, r);
      step();
      checks++;
      if (sat_res_valid !== pend || (pend && sat_res_pass !== pend_pass)) begin
        failures++; $display("[TB] FAIL mixed_cycle%0d got=%0b%0b want=%0b%0b",
                             i, sat_res_valid, sat_res_pass, pend, pend_pass);
      end
      if (pend && pend_pass) np++;
      if (pend && !pend_pass) nf++;
      if (acc && bad && !seen) begin
        seen  = 1'b1;
        first = {a, b, s, r, model_exp(a, b, s)};
      end
      pend      = acc;
      pend_pass = !bad;
    end
    checks++;
    if ({sat_pass_cnt, sat_fail_cnt, sat_err} !==
        {2'((np > 3) ? 3 : np), 2'((nf > 3) ? 3 : nf), seen}) begin
      failures++; $display("[TB] FAIL mixed_counts got=p%0d f%0d e%0b want=p%0d f%0d e%0b",
                           sat_pass_cnt, sat_fail_cnt, sat_err,
                           (np > 3) ? 3 : np, (nf > 3) ? 3 : nf, seen);
    end
    checks++;
    if ({sat_fail_op1, sat_fail_op2, sat_fail_sel, sat_fail_got, sat_fail_exp} !== first) begin
      failures++; $display("[TB] FAIL mixed_capture got=%0h want=%0h",
                           {sat_fail_op1, sat_fail_op2, sat_fail_sel, sat_fail_got, sat_fail_exp}, first);
    end
  endtask

  initial begin
    test_reset();
    test_directed_pass();
    test_stop_on_fail();
    test_clear_halt();
    test_clear_collision();
    test_reset_inflight();
    test_random_pass();
    test_saturation();
    test_random_mixed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
